// File: rtl/osiris_pkg.sv
// Shared definitions for the osiris_i host command bridge: command bytes and bridge FSM states.
package osiris_pkg;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_WB_CYCLE,
        ST_TX_LOAD,
        ST_TX_GUARD,
        ST_TX_WAIT
    } bridge_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_wb_cmd_bridge_timeout_ctr.sv
// Watchdog counter: cleared by i_clear, counts enabled cycles, flags expiry on the Nth one.
module bridge_timeout_ctr #(
    parameter int N = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] r_cnt;

    // Expiry is combinational so the FSM can act in the same cycle the limit is reached.
    assign o_expired = i_en && (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_wb_cmd_bridge.sv
// Host command decoder: UART frames {CMD, ADDR, DATA} in, single Wishbone classic cycles out,
// read data returned LSB-first through the UART transmitter.
module uart_wb_cmd_bridge #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BYTE_TIMEOUT = 500000,
    parameter int WB_TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_busy,
    input  logic                    i_select_mem,
    output logic                    o_mem_sel,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [ADDR_WIDTH-1:0]   o_wb_adr,
    output logic [DATA_WIDTH-1:0]   o_wb_dat,
    output logic [DATA_WIDTH/8-1:0] o_wb_sel,
    input  logic [DATA_WIDTH-1:0]   i_wb_dat,
    input  logic                    i_wb_ack,
    output logic                    o_busy,
    output logic                    o_error
);

    import osiris_pkg::*;

    localparam bridge_state_t IDLE     = ST_IDLE;
    localparam bridge_state_t GET_ADDR = ST_GET_ADDR;
    localparam bridge_state_t GET_DATA = ST_GET_DATA;
    localparam bridge_state_t WB_CYCLE = ST_WB_CYCLE;
    localparam bridge_state_t TX_LOAD  = ST_TX_LOAD;
    localparam bridge_state_t TX_GUARD = ST_TX_GUARD;
    localparam bridge_state_t TX_WAIT  = ST_TX_WAIT;

    localparam int ADDR_B = ADDR_WIDTH / 8;
    localparam int DATA_B = DATA_WIDTH / 8;
    localparam int MAX_B  = max_int(ADDR_B, DATA_B);
    localparam int BW     = (MAX_B > 1) ? $clog2(MAX_B) : 1;

    bridge_state_t         state;
    logic [BW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic w_in_get;
    logic w_byte_expired;
    logic w_wb_expired;
    logic w_addr_last;
    logic w_data_last;

    assign w_in_get    = (state == GET_ADDR) || (state == GET_DATA);
    assign w_addr_last = (r_idx == BW'(ADDR_B - 1));
    assign w_data_last = (r_idx == BW'(DATA_B - 1));
    assign o_busy      = (state != IDLE);

    // Inter-byte silence watchdog: restarted by every received byte of the frame.
    bridge_timeout_ctr #(.N(BYTE_TIMEOUT)) u_byte_to (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_in_get || i_rx_valid),
        .i_en      (w_in_get && !i_rx_valid),
        .o_expired (w_byte_expired)
    );

    bridge_timeout_ctr #(.N(WB_TIMEOUT)) u_wb_to (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (state != WB_CYCLE),
        .i_en      ((state == WB_CYCLE) && !i_wb_ack),
        .o_expired (w_wb_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            r_idx      <= '0;
            r_rd_data  <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_mem_sel  <= 1'b0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_adr   <= '0;
            o_wb_dat   <= '0;
            o_wb_sel   <= '0;
            o_error    <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_valid && (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ)) begin
                        o_wb_we   <= (i_rx_data == CMD_WRITE);
                        o_mem_sel <= i_select_mem;
                        r_idx     <= '0;
                        state     <= GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (i_rx_valid) begin
                        o_wb_adr[8*r_idx +: 8] <= i_rx_data;
                        if (w_addr_last) begin
                            r_idx <= '0;
                            if (o_wb_we) begin
                                state <= GET_DATA;
                            end else begin
                                o_wb_cyc <= 1'b1;
                                o_wb_stb <= 1'b1;
                                o_wb_sel <= '1;
                                state    <= WB_CYCLE;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (w_byte_expired) begin
                        r_idx   <= '0;
                        o_error <= 1'b1;
                        state   <= IDLE;
                    end
                end
                GET_DATA: begin
                    if (i_rx_valid) begin
                        o_wb_dat[8*r_idx +: 8] <= i_rx_data;
                        if (w_data_last) begin
                            r_idx    <= '0;
                            o_wb_cyc <= 1'b1;
                            o_wb_stb <= 1'b1;
                            o_wb_sel <= '1;
                            state    <= WB_CYCLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (w_byte_expired) begin
                        r_idx   <= '0;
                        o_error <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WB_CYCLE: begin
                    // A read that times out still answers the host, with zero data.
                    if (i_wb_ack || w_wb_expired) begin
                        o_wb_cyc  <= 1'b0;
                        o_wb_stb  <= 1'b0;
                        o_wb_sel  <= '0;
                        o_error   <= !i_wb_ack;
                        r_rd_data <= i_wb_ack ? i_wb_dat : '0;
                        state     <= o_wb_we ? IDLE : TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    if (!i_tx_busy) begin
                        o_tx_data  <= r_rd_data[8*r_idx +: 8];
                        o_tx_start <= 1'b1;
                        state      <= TX_GUARD;
                    end
                end
                TX_GUARD: begin
                    // Transmitter raises busy one cycle late; skip that cycle.
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (!i_tx_busy) begin
                        if (w_data_last) begin
                            r_idx <= '0;
                            state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            state <= TX_LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_cmd_bridge.sv
// Scoreboard bench for uart_wb_cmd_bridge: Wishbone slave and UART transmitter models check
// every bus cycle and transmitted byte against expectations queued when frames are sent.
module tb_uart_wb_cmd_bridge;

    localparam int BYTE_TO  = 40;
    localparam int WB_TO    = 20;
    localparam int ACK_WAIT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_busy;
    logic        i_select_mem;
    logic        o_mem_sel;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        o_busy;
    logic        o_error;

    uart_wb_cmd_bridge #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BYTE_TIMEOUT(BYTE_TO), .WB_TIMEOUT(WB_TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
        .i_select_mem(i_select_mem), .o_mem_sel(o_mem_sel),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack),
        .o_busy(o_busy), .o_error(o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        mem;
        logic        acked;
    } wb_exp_t;

    wb_exp_t    wb_q[$];
    logic [7:0] tx_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int err_pulses = 0;
    int stb_rises = 0;
    bit ack_en = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic mem, input logic acked);
        wb_exp_t e;
        e.we = we; e.adr = adr; e.dat = dat; e.mem = mem; e.acked = acked;
        wb_q.push_back(e);
    endtask

    task automatic push_tx_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
    endtask

    // Wishbone slave, UART transmitter and error-pulse monitor.
    initial begin : models
        wb_exp_t e;
        int      stb_len;
        int      busy_cnt;
        bit      prev_stb;
        i_wb_ack  = 1'b0;
        i_tx_busy = 1'b0;
        stb_len   = 0;
        busy_cnt  = 0;
        prev_stb  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                i_wb_ack  = 1'b0;
                i_tx_busy = 1'b0;
                stb_len   = 0;
                busy_cnt  = 0;
                prev_stb  = 1'b0;
                continue;
            end
            if (o_error) err_pulses++;
            if (o_wb_stb) begin
                if (!prev_stb) stb_rises++;
                stb_len++;
                if (ack_en && !i_wb_ack && stb_len > ACK_WAIT) begin
                    if (wb_q.size() == 0) begin
                        check_val("wb_unexpected_cycle", 32'd1, 32'd0);
                    end else begin
                        e = wb_q.pop_front();
                        check_val("wb_acked", 32'd1, {31'd0, e.acked});
                        check_val("wb_we", {31'd0, o_wb_we}, {31'd0, e.we});
                        check_val("wb_adr", o_wb_adr, e.adr);
                        if (e.we) check_val("wb_dat", o_wb_dat, e.dat);
                        check_val("wb_sel", {28'd0, o_wb_sel}, 32'hF);
                        check_val("wb_cyc", {31'd0, o_wb_cyc}, 32'd1);
                        check_val("mem_sel", {31'd0, o_mem_sel}, {31'd0, e.mem});
                    end
                    i_wb_ack = 1'b1;
                end
            end else begin
                if (prev_stb && !i_wb_ack) begin
                    if (wb_q.size() == 0) begin
                        check_val("wb_unexpected_abort", 32'd1, 32'd0);
                    end else begin
                        e = wb_q.pop_front();
                        check_val("wb_acked", 32'd0, {31'd0, e.acked});
                        check_val("wb_to_len", stb_len, WB_TO);
                        check_val("wb_to_adr", o_wb_adr, e.adr);
                    end
                end
                i_wb_ack = 1'b0;
                stb_len  = 0;
            end
            prev_stb = o_wb_stb;

            if (o_tx_start) begin
                check_val("tx_start_while_busy", {31'd0, i_tx_busy}, 32'd0);
                if (tx_q.size() == 0) check_val("tx_unexpected", 32'd1, 32'd0);
                else check_val("tx_byte", {24'd0, o_tx_data}, {24'd0, tx_q.pop_front()});
                i_tx_busy = 1'b1;
                busy_cnt  = 4;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) i_tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        check_val(tag, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_cyc_stb"}, {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        check_val({tag, "_sel"}, {28'd0, o_wb_sel}, 32'd0);
        check_val({tag, "_adr"}, o_wb_adr, 32'd0);
        check_val({tag, "_dat"}, o_wb_dat, 32'd0);
        check_val({tag, "_ctl"}, {26'd0, o_wb_we, o_mem_sel, o_busy, o_error, o_tx_start, 1'b0},
                  32'd0);
        check_val({tag, "_tx_data"}, {24'd0, o_tx_data}, 32'd0);
    endtask

    initial begin : stimulus
        int e0;
        int s0;
        rst          = 1'b1;
        i_rx_data    = 8'h00;
        i_rx_valid   = 1'b0;
        i_select_mem = 1'b0;
        i_wb_dat     = 32'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // 1: write with one-cycle ack; latency to stb and back to idle
        i_select_mem = 1'b1;
        push_wb(1'b1, 32'h0, 32'h0000_0093, 1'b1, 1'b1);
        send_byte(8'hAA);
        send_word(32'h0);
        send_word(32'h0000_0093);
        check_val("wr_stb_latency", {31'd0, o_wb_stb}, 32'd1);
        repeat (2) @(negedge clk);
        check_val("wr_idle_latency", {31'd0, o_busy}, 32'd0);
        check_val("wr_no_error", err_pulses, 0);

        // 2: reads, LSB-first reply, busy-gated starts
        i_select_mem = 1'b0;
        i_wb_dat     = 32'hA5A5_A5A5;
        push_wb(1'b0, 32'h4, 32'h0, 1'b0, 1'b1);
        push_tx_word(32'hA5A5_A5A5);
        send_byte(8'h01);
        send_word(32'h4);
        wait_idle("rd_a5_idle", 200);
        i_wb_dat = 32'h1122_3344;
        push_wb(1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        push_tx_word(32'h1122_3344);
        send_byte(8'h01);
        send_word(32'h1234_5678);
        wait_idle("rd_order_idle", 200);
        check_val("rd_tx_drained", tx_q.size(), 0);

        // 3: garbage bytes in IDLE are dropped
        send_byte(8'h55);
        send_byte(8'hFF);
        check_val("garbage_not_busy", {31'd0, o_busy}, 32'd0);
        i_select_mem = 1'b1;
        push_wb(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1, 1'b1);
        send_byte(8'hAA);
        send_word(32'h8);
        send_word(32'hDEAD_BEEF);
        wait_idle("garbage_wr_idle", 50);

        // 4: inter-byte timeout
        e0 = err_pulses;
        s0 = stb_rises;
        send_byte(8'hAA);
        send_byte(8'h10);
        repeat (BYTE_TO - 2) @(negedge clk);
        check_val("byte_to_not_early", {31'd0, o_busy}, 32'd1);
        wait_idle("byte_to_idle", 10);
        @(negedge clk);
        check_val("byte_to_error", err_pulses - e0, 1);
        check_val("byte_to_no_stb", stb_rises - s0, 0);

        // 5: read with no ack -> zero data returned
        ack_en   = 1'b0;
        e0       = err_pulses;
        i_wb_dat = 32'hFFFF_FFFF;
        push_wb(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        push_tx_word(32'h0);
        send_byte(8'h01);
        send_word(32'h10);
        wait_idle("noack_idle", WB_TO + 100);
        check_val("noack_error", err_pulses - e0, 1);
        check_val("noack_tx_drained", tx_q.size(), 0);
        ack_en = 1'b1;

        // 6: reset mid GET_DATA and mid WB_CYCLE
        send_byte(8'hAA);
        send_word(32'h20);
        send_byte(8'h11);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_get_data");
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b0;
        send_byte(8'hAA);
        send_word(32'h24);
        send_word(32'h5555_AAAA);
        repeat (2) @(negedge clk);
        check_val("pre_rst_stb", {31'd0, o_wb_stb}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_wb_cycle");
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        push_wb(1'b1, 32'h30, 32'h0BAD_F00D, 1'b0, 1'b1);
        i_select_mem = 1'b0;
        send_byte(8'hAA);
        send_word(32'h30);
        send_word(32'h0BAD_F00D);
        wait_idle("post_rst_idle", 50);
        check_val("wb_q_drained", wb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
